// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter that shares one req/gnt/rvalid register-bus slave among NUM_REQ requesters.
// Optional response timeout with orphan-response discard is enabled by defining ARB_TIMEOUT_EN.
module periph_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           aclk_i,
  input  logic                           areset_i,
  input  logic [NUM_REQ-1:0]             m_req_i,
  input  logic [NUM_REQ-1:0]             m_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  m_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] m_be_i,
  output logic [NUM_REQ-1:0]             m_gnt_o,
  output logic [NUM_REQ-1:0]             m_rvalid_o,
  output logic [DATA_WIDTH-1:0]          m_rdata_o,
  output logic                           m_err_o,
  output logic                           s_req_o,
  output logic                           s_we_o,
  output logic [ADDR_WIDTH-1:0]          s_addr_o,
  output logic [DATA_WIDTH-1:0]          s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        s_be_o,
  input  logic                           s_gnt_i,
  input  logic                           s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          s_rdata_i,
  input  logic                           s_err_i,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int BE_W  = DATA_WIDTH/8;
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        rr_ptr_q, idx_q;
  logic                    s_req_q, s_we_q;
  logic [ADDR_WIDTH-1:0]   s_addr_q;
  logic [DATA_WIDTH-1:0]   s_wdata_q;
  logic [BE_W-1:0]         s_be_q;

  logic                    pick_vld;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        nxt_ptr;
  logic                    done, abort;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_vld && m_req_i[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  assign nxt_ptr = (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] timer_q;
  logic [3:0]    orphan_q, orphan_d;
  logic          discard, orph_inc, in_txn;

  assign in_txn   = (state_q == ISSUE) || (state_q == WAIT_RSP);
  assign done     = (state_q == WAIT_RSP) && s_rvalid_i && (orphan_q == 4'd0);
  assign discard  = (state_q == WAIT_RSP) && s_rvalid_i && (orphan_q != 4'd0);
  assign abort    = in_txn && (timer_q == TW'(TIMEOUT_CYCLES-1)) && !done;
  // A grant taken in the abort cycle still leaves a response in flight.
  assign orph_inc = abort && ((state_q == WAIT_RSP) || s_gnt_i);

  always_comb begin
    orphan_d = orphan_q;
    if (discard && !orph_inc)
      orphan_d = orphan_q - 4'd1;
    else if (orph_inc && !discard && (orphan_q != 4'd15))
      orphan_d = orphan_q + 4'd1;
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      timer_q  <= '0;
      orphan_q <= '0;
    end else begin
      orphan_q <= orphan_d;
      if (state_q == IDLE)
        timer_q <= '0;
      else
        timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign done  = (state_q == WAIT_RSP) && s_rvalid_i;
  assign abort = 1'b0;
`endif

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            idx_q     <= pick_idx;
            s_req_q   <= 1'b1;
            s_we_q    <= m_we_i[pick_idx];
            s_addr_q  <= m_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_wdata_q <= m_wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            s_be_q    <= m_be_i[pick_idx*BE_W +: BE_W];
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            s_req_q  <= 1'b0;
            rr_ptr_q <= nxt_ptr;
            state_q  <= IDLE;
          end else if (s_gnt_i) begin
            s_req_q  <= 1'b0;
            state_q  <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (done || abort) begin
            rr_ptr_q <= nxt_ptr;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant and response paths are combinational; reset forces them low.
  assign m_gnt_o    = (!areset_i && (state_q == IDLE) && pick_vld) ? onehot(pick_idx) : '0;
  assign m_rvalid_o = (!areset_i && (done || abort)) ? onehot(idx_q) : '0;
  assign m_rdata_o  = (!areset_i && done) ? s_rdata_i : '0;
  assign m_err_o    = !areset_i && (done ? s_err_i : abort);
  assign timeout_o  = !areset_i && abort;

  assign s_req_o   = s_req_q;
  assign s_we_o    = s_we_q;
  assign s_addr_o  = s_addr_q;
  assign s_wdata_o = s_wdata_q;
  assign s_be_o    = s_be_q;
  assign busy_o    = (state_q != IDLE);

endmodule
